hash_state_chain: RTL and testbench

Parametrised chaining-value register bank for the double SHA-256 mining datapath. Holds all NUM_WORDS working hash words (H0..H7), sequences block 1 (header part 1), block 2 (header part 2 + nonce) and block 3 (second hash of the 256-bit first digest) under an explicit state machine, and caches the block-1 midstate so that each new nonce skips block 1. Sits between the nonce controller and the compression round engine; replaces the per-word state registers.

---
 rtl/hash_pkg.sv | 24 ++
 rtl/word_vec_add.sv | 18 +
 rtl/hash_state_chain.sv | 168 ++++++++++++++++
 tb/tb_hash_state_chain.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// hash_pkg: shared constants and types for the double SHA-256 chaining-value
// bank.
//   HASH_WORD_W   default hash word width
//   HASH_NUM_W    default number of chaining words
//   SHA256_IV     SHA-256 initial hash value, H0 in the MSBs
//   hash_state_t  block sequencer state, encoded to match the phase output
package hash_pkg;

    localparam int HASH_WORD_W = 32;
    localparam int HASH_NUM_W  = 8;

    localparam logic [HASH_NUM_W*HASH_WORD_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BLK1 = 2'd1,
        ST_BLK2 = 2'd2,
        ST_BLK3 = 2'd3
    } hash_state_t;

endpackage

// File: rtl/word_vec_add.sv
// word_vec_add: NUM_WORDS independent modular adders (combinational).
// Each WORD_W slice wraps on its own; no carry crosses a word boundary.
//   a, b  packed input vectors, word 0 in the LSBs
//   sum   packed per-word sums
module word_vec_add #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8
) (
    input  logic [NUM_WORDS*WORD_W-1:0] a,
    input  logic [NUM_WORDS*WORD_W-1:0] b,
    output logic [NUM_WORDS*WORD_W-1:0] sum
);

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
        assign sum[i*WORD_W +: WORD_W] = a[i*WORD_W +: WORD_W] + b[i*WORD_W +: WORD_W];
    end

endmodule

// File: rtl/hash_state_chain.sv
// hash_state_chain: chaining-value register bank and block sequencer for the
// double SHA-256 mining datapath (block 1, block 2 + nonce, block 3 = second
// hash). Optional macro HASH_MIDSTATE_EN caches the block-1 result so each new
// nonce restarts directly at block 2; without it nonce_next recomputes block 1.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a new header from IV (aborts any block)
//   nonce_next            next nonce from cached midstate
//   comp_valid, comp_in   compression engine result pulse and a..h words
//   h_out                 chaining value for the current block
//   phase                 0 idle, 1 block 1, 2 block 2, 3 block 3
//   hash1_out             first-hash digest (message for block 3)
//   digest, digest_valid  final double hash and its one-cycle strobe
//   mid_valid             midstate cache valid
//   proto_err             sticky protocol-violation flag
module hash_state_chain
    import hash_pkg::*;
#(
    parameter int WORD_W    = HASH_WORD_W,
    parameter int NUM_WORDS = HASH_NUM_W,
    parameter logic [NUM_WORDS*WORD_W-1:0] IV = SHA256_IV
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        nonce_next,
    input  logic                        comp_valid,
    input  logic [NUM_WORDS*WORD_W-1:0] comp_in,
    output logic [NUM_WORDS*WORD_W-1:0] h_out,
    output logic [1:0]                  phase,
    output logic [NUM_WORDS*WORD_W-1:0] hash1_out,
    output logic [NUM_WORDS*WORD_W-1:0] digest,
    output logic                        digest_valid,
    output logic                        mid_valid,
    output logic                        proto_err
);

    localparam int VW = NUM_WORDS * WORD_W;

    hash_state_t   st, st_n;
    logic [VW-1:0] h_r, h_n;
    logic [VW-1:0] h1_r, h1_n;
    logic [VW-1:0] dig_r, dig_n;
    logic          dv_r, dv_n;
    logic          pe_r, pe_n;
    logic [VW-1:0] sum;
    logic          restart;

    // All three update paths add the same operands: current chaining value
    // plus engine output.
    word_vec_add #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) u_add (
        .a   (h_r),
        .b   (comp_in),
        .sum (sum)
    );

`ifdef HASH_MIDSTATE_EN
    logic [VW-1:0] mid_r, mid_n;
    logic          mv_r, mv_n;
    assign restart = start;
`else
    // Without the cache a new nonce is just a fresh header.
    assign restart = start | nonce_next;
`endif

    always_comb begin
        st_n  = st;
        h_n   = h_r;
        h1_n  = h1_r;
        dig_n = dig_r;
        dv_n  = 1'b0;
        pe_n  = pe_r;
`ifdef HASH_MIDSTATE_EN
        mid_n = mid_r;
        mv_n  = mv_r;
`endif
        if (restart) begin
            st_n = ST_BLK1;
            h_n  = IV;
`ifdef HASH_MIDSTATE_EN
            mv_n = 1'b0;
`endif
        end else begin
`ifdef HASH_MIDSTATE_EN
            if (nonce_next) begin
                if (st == ST_IDLE && mv_r) begin
                    st_n = ST_BLK2;
                    h_n  = mid_r;
                end else begin
                    pe_n = 1'b1;
                end
            end
`endif
            // nonce_next never leaves a non-IDLE state, so comp_valid is
            // still honoured alongside an ignored nonce_next.
            if (comp_valid) begin
                unique case (st)
                    ST_IDLE: pe_n = 1'b1;
                    ST_BLK1: begin
                        h_n  = sum;
                        st_n = ST_BLK2;
`ifdef HASH_MIDSTATE_EN
                        mid_n = sum;
                        mv_n  = 1'b1;
`endif
                    end
                    ST_BLK2: begin
                        h1_n = sum;
                        h_n  = IV;
                        st_n = ST_BLK3;
                    end
                    ST_BLK3: begin
                        dig_n = sum;
                        dv_n  = 1'b1;
                        st_n  = ST_IDLE;
`ifdef HASH_MIDSTATE_EN
                        h_n = mid_r;
`else
                        h_n = IV;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= ST_IDLE;
            h_r   <= IV;
            h1_r  <= '0;
            dig_r <= '0;
            dv_r  <= 1'b0;
            pe_r  <= 1'b0;
        end else begin
            st    <= st_n;
            h_r   <= h_n;
            h1_r  <= h1_n;
            dig_r <= dig_n;
            dv_r  <= dv_n;
            pe_r  <= pe_n;
        end
    end

`ifdef HASH_MIDSTATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_r <= IV;
            mv_r  <= 1'b0;
        end else begin
            mid_r <= mid_n;
            mv_r  <= mv_n;
        end
    end
    assign mid_valid = mv_r;
`else
    assign mid_valid = 1'b0;
`endif

    assign h_out        = h_r;
    assign phase        = st;
    assign hash1_out    = h1_r;
    assign digest       = dig_r;
    assign digest_valid = dv_r;
    assign proto_err    = pe_r;

endmodule

// File: tb/tb_hash_state_chain.sv
// tb_hash_state_chain: directed self-checking bench for hash_state_chain.
// Expectations follow HASH_MIDSTATE_EN when the bench is built with it.
module tb_hash_state_chain;

    localparam logic [255:0] IV_C = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    // IV + ffffffff per word = IV - 1 per word
    localparam logic [255:0] M1_C = {
        32'h6a09e666, 32'hbb67ae84, 32'h3c6ef371, 32'ha54ff539,
        32'h510e527e, 32'h9b05688b, 32'h1f83d9aa, 32'h5be0cd18
    };
`ifdef HASH_MIDSTATE_EN
    localparam bit MID_EN = 1'b1;
`else
    localparam bit MID_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         nonce_next = 1'b0;
    logic         comp_valid = 1'b0;
    logic [255:0] comp_in = '0;
    logic [255:0] h_out, hash1_out, digest;
    logic [1:0]   phase;
    logic         digest_valid, mid_valid, proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    hash_state_chain dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .nonce_next   (nonce_next),
        .comp_valid   (comp_valid),
        .comp_in      (comp_in),
        .h_out        (h_out),
        .phase        (phase),
        .hash1_out    (hash1_out),
        .digest       (digest),
        .digest_valid (digest_valid),
        .mid_valid    (mid_valid),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; nonce_next = 0; comp_valid = 0; comp_in = '0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic pulse_comp(input logic [255:0] v);
        comp_valid = 1; comp_in = v;
        tick();
        comp_valid = 0; comp_in = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (h_out !== IV_C) begin n_fail++; $display("FAIL reset_h_out got %h want %h", h_out, IV_C); end
        n_tests++; if (phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase got %0d want 0", phase); end
        n_tests++; if ({hash1_out, digest} !== 512'd0) begin n_fail++; $display("FAIL reset_hash1_digest got %h %h want 0", hash1_out, digest); end
        n_tests++; if ({digest_valid, mid_valid, proto_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {digest_valid, mid_valid, proto_err}); end
    endtask

    task automatic test_full_run_back_to_back();
        do_reset();
        start = 1; tick(); start = 0;
        n_tests++; if (phase !== 2'd1 || h_out !== IV_C) begin n_fail++; $display("FAIL start_blk1 got phase %0d h %h want 1 %h", phase, h_out, IV_C); end
        pulse_comp({8{32'hffffffff}});
        n_tests++; if (phase !== 2'd2 || h_out !== M1_C) begin n_fail++; $display("FAIL blk1_update got phase %0d h %h want 2 %h", phase, h_out, M1_C); end
        n_tests++; if (h_out[255:224] !== 32'h6a09e666 || h_out[223:192] !== 32'hbb67ae84) begin n_fail++; $display("FAIL blk1_h0h1 got %h %h want 6a09e666 bb67ae84", h_out[255:224], h_out[223:192]); end
        n_tests++; if (mid_valid !== MID_EN) begin n_fail++; $display("FAIL blk1_mid_valid got %b want %b", mid_valid, MID_EN); end
        pulse_comp('0);
        n_tests++; if (phase !== 2'd3 || hash1_out !== M1_C || h_out !== IV_C || digest_valid !== 1'b0) begin
            n_fail++; $display("FAIL blk2_update got phase %0d hash1 %h h %h dv %b", phase, hash1_out, h_out, digest_valid); end
        pulse_comp('0);
        n_tests++; if (phase !== 2'd0 || digest !== IV_C || digest_valid !== 1'b1) begin
            n_fail++; $display("FAIL blk3_update got phase %0d digest %h dv %b want 0 %h 1", phase, digest, digest_valid, IV_C); end
        n_tests++; if (h_out !== (MID_EN ? M1_C : IV_C)) begin n_fail++; $display("FAIL blk3_h_out got %h", h_out); end
        // nonce_next while digest_valid is still high
        nonce_next = 1; tick(); nonce_next = 0;
        n_tests++; if (digest_valid !== 1'b0) begin n_fail++; $display("FAIL dv_single_pulse got %b want 0", digest_valid); end
        n_tests++; if (phase !== (MID_EN ? 2'd2 : 2'd1) || h_out !== (MID_EN ? M1_C : IV_C) || proto_err !== 1'b0) begin
            n_fail++; $display("FAIL back_to_back_nonce got phase %0d h %h pe %b", phase, h_out, proto_err); end
        if (MID_EN) begin
            // in BLK2: nonce_next is a violation and is ignored
            nonce_next = 1; tick(); nonce_next = 0;
            n_tests++; if (phase !== 2'd2 || proto_err !== 1'b1) begin n_fail++; $display("FAIL nonce_in_blk2 got phase %0d pe %b want 2 1", phase, proto_err); end
        end
    endtask

    task automatic test_nonce_before_start();
        do_reset();
        nonce_next = 1; tick(); nonce_next = 0;
        n_tests++; if (phase !== (MID_EN ? 2'd0 : 2'd1) || proto_err !== MID_EN) begin
            n_fail++; $display("FAIL nonce_idle got phase %0d pe %b want %0d %b", phase, proto_err, MID_EN ? 0 : 1, MID_EN); end
        tick();
        n_tests++; if (proto_err !== MID_EN) begin n_fail++; $display("FAIL pe_sticky got %b want %b", proto_err, MID_EN); end
    endtask

    task automatic test_abort();
        do_reset();
        start = 1; tick(); start = 0;
        pulse_comp({8{32'hffffffff}});
        pulse_comp('0);
        n_tests++; if (phase !== 2'd3) begin n_fail++; $display("FAIL abort_reach_blk3 got %0d want 3", phase); end
        start = 1; tick(); start = 0;
        n_tests++; if (phase !== 2'd1 || h_out !== IV_C || mid_valid !== 1'b0 || proto_err !== 1'b0) begin
            n_fail++; $display("FAIL abort_restart got phase %0d h %h mv %b pe %b", phase, h_out, mid_valid, proto_err); end
    endtask

    task automatic test_comp_idle();
        do_reset();
        pulse_comp({8{32'h12345678}});
        n_tests++; if (phase !== 2'd0 || proto_err !== 1'b1 || h_out !== IV_C) begin
            n_fail++; $display("FAIL comp_idle got phase %0d pe %b h %h", phase, proto_err, h_out); end
    endtask

    task automatic test_word_wrap();
        do_reset();
        start = 1; tick(); start = 0;
        pulse_comp({8{32'h95f61999}});
        n_tests++; if (h_out[255:224] !== 32'h00000000 || h_out[223:192] !== 32'h515dc81e || h_out[31:0] !== 32'hf1d6e6b2) begin
            n_fail++; $display("FAIL word_wrap got %h %h %h want 00000000 515dc81e f1d6e6b2", h_out[255:224], h_out[223:192], h_out[31:0]); end
    endtask

    task automatic test_async_reset_mid_blk2();
        do_reset();
        start = 1; tick(); start = 0;
        pulse_comp({8{32'hffffffff}});
        #2 rst_n = 0;
        #1;
        n_tests++; if (phase !== 2'd0 || h_out !== IV_C || mid_valid !== 1'b0 || proto_err !== 1'b0 || digest_valid !== 1'b0 || {hash1_out, digest} !== 512'd0) begin
            n_fail++; $display("FAIL async_reset got phase %0d h %h mv %b", phase, h_out, mid_valid); end
        tick();
        rst_n = 1;
        tick();
        if (MID_EN) begin
            nonce_next = 1; tick(); nonce_next = 0;
            n_tests++; if (phase !== 2'd0 || proto_err !== 1'b1) begin n_fail++; $display("FAIL midstate_lost got phase %0d pe %b want 0 1", phase, proto_err); end
        end
    endtask

    initial begin
        test_reset();
        test_full_run_back_to_back();
        test_nonce_before_start();
        test_abort();
        test_comp_idle();
        test_word_wrap();
        test_async_reset_mid_blk2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
